// File: rtl/dlx_single_cycle_core.sv
// Single-cycle 32-bit big-endian DLX integer core: one instruction fetched,
// decoded, executed and retired per clock. All buses are [0:31], bit 0 = MSB.
module dlx_single_cycle_core #(
  parameter logic [0:31] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [0:31] iaddr,
  input  logic [0:31] inst_from_mem,
  output logic [0:31] addr_to_mem,
  output logic [0:31] data_to_mem,
  input  logic [0:31] data_from_mem,
  output logic        write_enable_to_mem,
  output logic        byte_to_mem,
  output logic        half_word_to_mem,
  output logic        sign_extend_to_mem
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQZ = 6'h04,
    OP_BNEZ  = 6'h05, OP_ADDI = 6'h08, OP_ADDUI = 6'h09, OP_SUBI = 6'h0a,
    OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e, OP_LHI  = 6'h0f,
    OP_JR    = 6'h12, OP_JALR = 6'h13, OP_SLLI = 6'h14, OP_SRLI = 6'h16,
    OP_SRAI  = 6'h17, OP_SEQI = 6'h18, OP_SNEI = 6'h19, OP_SLTI = 6'h1a,
    OP_SGTI  = 6'h1b, OP_SLEI = 6'h1c, OP_SGEI = 6'h1d, OP_LB   = 6'h20,
    OP_LH    = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24, OP_LHU  = 6'h25,
    OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2b
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL = 6'h04, FN_SRL = 6'h06, FN_SRA = 6'h07,
    FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
    FN_SEQ = 6'h28, FN_SNE = 6'h29, FN_SLT = 6'h2a, FN_SGT = 6'h2b,
    FN_SLE = 6'h2c, FN_SGE = 6'h2d
  } func_e;

  // Set-compare selector is the low three bits of both func and opcode.
  function automatic logic compare(input logic [0:2] sel, input logic [0:31] a,
                                   input logic [0:31] b);
    logic r;
    case (sel)
      3'd0:    r = (a == b);
      3'd1:    r = (a != b);
      3'd2:    r = ($signed(a) <  $signed(b));
      3'd3:    r = ($signed(a) >  $signed(b));
      3'd4:    r = ($signed(a) <= $signed(b));
      default: r = ($signed(a) >= $signed(b));
    endcase
    return r;
  endfunction

  logic [0:31] pc, pc_plus4, pc_plus8, next_pc;
  logic [0:31] rf [0:31];
  logic [0:5]  op, func;
  logic [0:4]  rs1, rs2, rd_r, rd_i;
  logic [0:31] rs1_val, rs2_val;
  logic [0:31] imm_sext, imm_zext, off_sext;
  logic        wr_en;
  logic [0:4]  wr_addr;
  logic [0:31] wr_data;

  assign op       = inst_from_mem[0:5];
  assign rs1      = inst_from_mem[6:10];
  assign rs2      = inst_from_mem[11:15];
  assign rd_i     = inst_from_mem[11:15];
  assign rd_r     = inst_from_mem[16:20];
  assign func     = inst_from_mem[26:31];
  assign imm_sext = {{16{inst_from_mem[16]}}, inst_from_mem[16:31]};
  assign imm_zext = {16'h0000, inst_from_mem[16:31]};
  assign off_sext = {{6{inst_from_mem[6]}}, inst_from_mem[6:31]};

  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;
  assign iaddr    = pc;

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

  // Store data comes from the I-type rd field, which is the rs2 read port.
  assign addr_to_mem = rs1_val + imm_sext;
  assign data_to_mem = rs2_val;

  always_comb begin
    next_pc             = pc_plus4;
    wr_en               = 1'b0;
    wr_addr             = rd_i;
    wr_data             = '0;
    write_enable_to_mem = 1'b0;
    byte_to_mem         = 1'b0;
    half_word_to_mem    = 1'b0;
    sign_extend_to_mem  = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_addr = rd_r;
        wr_en   = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: wr_data = rs1_val + rs2_val;
          FN_SUB, FN_SUBU: wr_data = rs1_val - rs2_val;
          FN_AND:          wr_data = rs1_val & rs2_val;
          FN_OR:           wr_data = rs1_val | rs2_val;
          FN_XOR:          wr_data = rs1_val ^ rs2_val;
          FN_SLL:          wr_data = rs1_val << rs2_val[27:31];
          FN_SRL:          wr_data = rs1_val >> rs2_val[27:31];
          FN_SRA:          wr_data = $signed(rs1_val) >>> rs2_val[27:31];
          FN_SEQ, FN_SNE, FN_SLT, FN_SGT, FN_SLE, FN_SGE:
            wr_data = {31'b0, compare(func[3:5], rs1_val, rs2_val)};
          default:         wr_en = 1'b0;
        endcase
      end
      OP_ADDI:  begin wr_en = 1'b1; wr_data = rs1_val + imm_sext; end
      OP_SUBI:  begin wr_en = 1'b1; wr_data = rs1_val - imm_sext; end
      OP_ADDUI: begin wr_en = 1'b1; wr_data = rs1_val + imm_zext; end
      OP_ANDI:  begin wr_en = 1'b1; wr_data = rs1_val & imm_zext; end
      OP_ORI:   begin wr_en = 1'b1; wr_data = rs1_val | imm_zext; end
      OP_XORI:  begin wr_en = 1'b1; wr_data = rs1_val ^ imm_zext; end
      OP_LHI:   begin wr_en = 1'b1; wr_data = {inst_from_mem[16:31], 16'h0000}; end
      OP_SLLI:  begin wr_en = 1'b1; wr_data = rs1_val << inst_from_mem[27:31]; end
      OP_SRLI:  begin wr_en = 1'b1; wr_data = rs1_val >> inst_from_mem[27:31]; end
      OP_SRAI:  begin wr_en = 1'b1; wr_data = $signed(rs1_val) >>> inst_from_mem[27:31]; end
      OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
        wr_en   = 1'b1;
        wr_data = {31'b0, compare(op[3:5], rs1_val, imm_sext)};
      end
      OP_BEQZ: if (rs1_val == '0) next_pc = pc_plus4 + imm_sext;
      OP_BNEZ: if (rs1_val != '0) next_pc = pc_plus4 + imm_sext;
      OP_J:    next_pc = pc_plus4 + off_sext;
      OP_JAL: begin
        next_pc = pc_plus4 + off_sext;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus8;
      end
      OP_JR:   next_pc = rs1_val;
      OP_JALR: begin
        next_pc = rs1_val;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc_plus8;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        wr_en              = 1'b1;
        wr_data            = data_from_mem;
        byte_to_mem        = (op == OP_LB) || (op == OP_LBU);
        half_word_to_mem   = (op == OP_LH) || (op == OP_LHU);
        sign_extend_to_mem = (op == OP_LB) || (op == OP_LH);
      end
      OP_SB, OP_SH, OP_SW: begin
        write_enable_to_mem = ~reset;
        byte_to_mem         = (op == OP_SB);
        half_word_to_mem    = (op == OP_SH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wr_en && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_dlx_single_cycle_core.sv
// Directed bench for dlx_single_cycle_core: a per-cycle expected trace table
// plus a hand-checked sum loop with JAL/JR, against small imem/dmem models.
module tb_dlx_single_cycle_core;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [0:31] iaddr, inst_from_mem, addr_to_mem, data_to_mem, data_from_mem;
  logic        write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;

  int n_checks = 0;
  int n_errors = 0;

  dlx_single_cycle_core #(.RESET_PC(32'h00000000)) dut (
    .clock(clock), .reset(reset), .iaddr(iaddr), .inst_from_mem(inst_from_mem),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem), .data_from_mem(data_from_mem),
    .write_enable_to_mem(write_enable_to_mem), .byte_to_mem(byte_to_mem),
    .half_word_to_mem(half_word_to_mem), .sign_extend_to_mem(sign_extend_to_mem)
  );

  always #5 clock = ~clock;

  logic [31:0] imem [0:255];
  logic [7:0]  dmem [0:16383];
  logic [31:0] ia, da, dd;
  logic [13:0] ba, ha, wa;

  assign ia = iaddr;
  assign da = addr_to_mem;
  assign dd = data_to_mem;
  assign inst_from_mem = imem[ia[9:2]];

  // Big-endian data memory: lane select and extension as dmem would do it.
  always_comb begin
    ba = da[13:0];
    ha = {da[13:1], 1'b0};
    wa = {da[13:2], 2'b00};
    if (byte_to_mem)
      data_from_mem = sign_extend_to_mem ? {{24{dmem[ba][7]}}, dmem[ba]} : {24'h0, dmem[ba]};
    else if (half_word_to_mem)
      data_from_mem = sign_extend_to_mem ? {{16{dmem[ha][7]}}, dmem[ha], dmem[ha + 14'd1]}
                                         : {16'h0, dmem[ha], dmem[ha + 14'd1]};
    else
      data_from_mem = {dmem[wa], dmem[wa + 14'd1], dmem[wa + 14'd2], dmem[wa + 14'd3]};
  end

  // Preload while reset is held; otherwise perform the core's stores.
  always @(posedge clock) begin
    if (reset) begin
      dmem[14'h2000] <= 8'h00; dmem[14'h2001] <= 8'h00;
      dmem[14'h2002] <= 8'h00; dmem[14'h2003] <= 8'h2a;
      for (int k = 0; k < 10; k++) begin
        dmem[14'h1000 + 14'(4*k)]     <= 8'h00;
        dmem[14'h1000 + 14'(4*k) + 1] <= 8'h00;
        dmem[14'h1000 + 14'(4*k) + 2] <= 8'h00;
        dmem[14'h1000 + 14'(4*k) + 3] <= 8'(3*k + 1);
      end
    end else if (write_enable_to_mem) begin
      if (byte_to_mem) dmem[ba] <= dd[7:0];
      else if (half_word_to_mem) begin
        dmem[ha] <= dd[15:8]; dmem[ha + 14'd1] <= dd[7:0];
      end else begin
        dmem[wa] <= dd[31:24];          dmem[wa + 14'd1] <= dd[23:16];
        dmem[wa + 14'd2] <= dd[15:8];   dmem[wa + 14'd3] <= dd[7:0];
      end
    end
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        we;
    logic [2:0]  bhs;      // {byte, half, sign_extend}
    logic        chk_addr;
    logic [31:0] addr;
    logic        chk_data;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] enc_i(input int op, input int rs1, input int rd, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs1[4:0], rd[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_r(input int rs1, input int rs2, input int rd, input int fn);
    logic [31:0] w;
    w = {6'h00, rs1[4:0], rs2[4:0], rd[4:0], 5'h00, fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int off);
    logic [31:0] w;
    w = {op[5:0], off[25:0]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, got, exp);
    end
  endtask

  task automatic alu_v(input logic [31:0] pc, input logic [31:0] inst);
    vecs.push_back('{inst, pc, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0});
  endtask
  task automatic ld_v(input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] bhs,
                      input logic [31:0] a);
    vecs.push_back('{inst, pc, 1'b0, bhs, 1'b1, a, 1'b0, 32'h0});
  endtask
  task automatic st_v(input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] bhs,
                      input logic [31:0] a, input logic [31:0] d);
    vecs.push_back('{inst, pc, 1'b1, bhs, 1'b1, a, 1'b1, d});
  endtask
  // Register probe: SW 0x3000(r0), rN exposes rN on data_to_mem.
  task automatic probe(input logic [31:0] pc, input int r, input logic [31:0] d);
    st_v(pc, enc_i('h2b, 0, r, 'h3000), 3'b000, 32'h3000, d);
  endtask

  initial begin
    int taken;
    logic [31:0] prev;
    bit done;

    for (int i = 0; i < 256; i++) imem[i] = 32'h0;

    probe(32'h00, 0, 32'h0);
    alu_v(32'h04, enc_i('h08, 0, 6, 0));
    ld_v (32'h08, enc_i('h23, 6, 4, 'h2000), 3'b000, 32'h2000);
    alu_v(32'h0C, enc_i('h08, 4, 5, 1));
    st_v (32'h10, enc_i('h2b, 0, 5, 'h2028), 3'b000, 32'h2028, 32'd43);
    ld_v (32'h14, enc_i('h23, 0, 7, 'h2028), 3'b000, 32'h2028);
    probe(32'h18, 7, 32'd43);
    alu_v(32'h1C, enc_i('h08, 0, 1, 'h80));
    st_v (32'h20, enc_i('h28, 0, 1, 'h2100), 3'b100, 32'h2100, 32'h80);
    ld_v (32'h24, enc_i('h20, 0, 1, 'h2100), 3'b101, 32'h2100);
    probe(32'h28, 1, 32'hFFFFFF80);
    ld_v (32'h2C, enc_i('h24, 0, 2, 'h2100), 3'b100, 32'h2100);
    probe(32'h30, 2, 32'h00000080);
    st_v (32'h34, enc_i('h29, 0, 1, 'h2102), 3'b010, 32'h2102, 32'hFFFFFF80);
    ld_v (32'h38, enc_i('h21, 0, 3, 'h2102), 3'b011, 32'h2102);
    ld_v (32'h3C, enc_i('h25, 0, 8, 'h2102), 3'b010, 32'h2102);
    probe(32'h40, 3, 32'hFFFFFF80);
    probe(32'h44, 8, 32'h0000FF80);
    alu_v(32'h48, enc_i('h08, 0, 0, 5));
    alu_v(32'h4C, enc_i('h08, 0, 3, -1));
    alu_v(32'h50, enc_r(0, 3, 2, 'h2a));
    alu_v(32'h54, enc_r(0, 3, 9, 'h2b));
    probe(32'h58, 0, 32'h0);
    probe(32'h5C, 2, 32'h0);
    probe(32'h60, 9, 32'h1);
    alu_v(32'h64, enc_i('h0f, 0, 10, 'h8000));
    alu_v(32'h68, enc_i('h0d, 10, 10, 'h00F0));
    alu_v(32'h6C, enc_i('h17, 10, 11, 4));
    alu_v(32'h70, enc_i('h16, 10, 12, 4));
    probe(32'h74, 11, 32'hF800000F);
    probe(32'h78, 12, 32'h0800000F);
    alu_v(32'h7C, enc_i('h08, 0, 13, 3));
    alu_v(32'h80, enc_r(10, 13, 14, 'h04));
    alu_v(32'h84, enc_r(0, 13, 15, 'h22));
    alu_v(32'h88, enc_r(15, 10, 16, 'h26));
    probe(32'h8C, 14, 32'h00000780);
    probe(32'h90, 15, 32'hFFFFFFFD);
    probe(32'h94, 16, 32'h7FFFFF0D);
    alu_v(32'h98, enc_i('h0c, 15, 17, 'hFF0F));
    probe(32'h9C, 17, 32'h0000FF0D);
    alu_v(32'hA0, enc_r(10, 10, 18, 'h20));
    probe(32'hA4, 18, 32'h000001E0);
    alu_v(32'hA8, enc_i('h04, 0, 0, 8));
    alu_v(32'hB4, enc_i('h05, 0, 0, 'h40));
    alu_v(32'hB8, enc_i('h15, 0, 1, 'h1234));
    alu_v(32'hBC, 32'h00000000);
    probe(32'hC0, 1, 32'hFFFFFF80);
    alu_v(32'hC4, enc_i('h08, 0, 20, 'hD0));
    alu_v(32'hC8, enc_i('h13, 20, 0, 0));
    probe(32'hD0, 31, 32'h000000D0);
    alu_v(32'hD4, enc_i('h1d, 15, 21, -3));
    probe(32'hD8, 21, 32'h1);
    alu_v(32'hDC, enc_i('h0a, 0, 22, 1));
    probe(32'hE0, 22, 32'hFFFFFFFF);
    alu_v(32'hE4, enc_i('h09, 0, 23, 'hFFFF));
    probe(32'hE8, 23, 32'h0000FFFF);

    foreach (vecs[i]) imem[vecs[i].pc[9:2]] = vecs[i].inst;

    // Reset with a store sitting at the reset PC: no write may escape.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset iaddr", ia, 32'h0);
    check("reset we", {31'b0, write_enable_to_mem}, 32'h0);
    reset = 1'b0;
    #1;

    foreach (vecs[i]) begin
      check($sformatf("v%0d iaddr", i), ia, vecs[i].pc);
      check($sformatf("v%0d we", i), {31'b0, write_enable_to_mem}, {31'b0, vecs[i].we});
      check($sformatf("v%0d bhs", i),
            {29'b0, byte_to_mem, half_word_to_mem, sign_extend_to_mem}, {29'b0, vecs[i].bhs});
      if (vecs[i].chk_addr) check($sformatf("v%0d addr", i), da, vecs[i].addr);
      if (vecs[i].chk_data) check($sformatf("v%0d data", i), dd, vecs[i].data);
      @(negedge clock);
    end

    check("mem 0x2028", {dmem[14'h2028], dmem[14'h2029], dmem[14'h202a], dmem[14'h202b]}, 32'd43);
    check("mem 0x2100", {24'h0, dmem[14'h2100]}, 32'h80);
    check("mem 0x2102", {16'h0, dmem[14'h2102], dmem[14'h2103]}, 32'hFF80);

    // Second program: sum loop, JAL/JR round trip; reset must clear registers.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = enc_i('h2b, 0, 0, 'h3FF0);
    imem[0]  = enc_i('h08, 0, 1, 'h1000);
    imem[1]  = enc_i('h08, 0, 2, 10);
    imem[2]  = enc_i('h08, 0, 3, 0);
    imem[3]  = enc_i('h23, 1, 4, 0);
    imem[4]  = enc_r(3, 4, 3, 'h20);
    imem[5]  = enc_i('h08, 1, 1, 4);
    imem[6]  = enc_i('h0a, 2, 2, 1);
    imem[7]  = enc_i('h05, 2, 0, -20);
    imem[8]  = enc_j('h03, 'h10);
    imem[10] = enc_i('h2b, 0, 3, 'h3004);
    imem[11] = enc_j('h02, -4);
    imem[13] = enc_i('h12, 31, 0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("B reset iaddr", ia, 32'h0);
    check("B reset r1 cleared", dd, 32'h0);
    reset = 1'b0;
    #1;

    taken = 0;
    prev  = 32'hFFFFFFFF;
    done  = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (prev == 32'h1C && ia == 32'h0C) taken++;
      if (prev == 32'h20) check("jal target", ia, 32'h34);
      if (prev == 32'h34) check("jr target", ia, 32'h28);
      if (ia == 32'h28 && prev != 32'h28) begin
        check("sum we", {31'b0, write_enable_to_mem}, 32'h1);
        check("sum addr", da, 32'h3004);
        check("sum data", dd, 32'd145);
      end
      if (ia == 32'h2C) done = 1'b1;
      else begin
        prev = ia;
        @(negedge clock);
      end
    end
    if (!done) check("loop reached end", 32'h0, 32'h1);
    check("branch taken count", taken, 32'd9);
    check("mem sum", {dmem[14'h3004], dmem[14'h3005], dmem[14'h3006], dmem[14'h3007]}, 32'd145);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
